multi_stack: RTL
================

// Module: multi_stack
// PURPOSE
//  NUM_CH independent LIFO stacks sharing one push port and one pop port.
//  Each port has its own channel select. Used by the tree-traversal engine
//  to hold a DFS node stack per in-flight packet context.
//  Additions over the single-channel stack:
//   - same-cycle push+pop (replace-top)
//   - peek of the current top
//   - per-channel clear
//   - sticky overflow/underflow flags
//  Popped data is registered and qualified by pop_valid.
// PARAMETERS
//  DATA_WIDTH  8    bits per entry
//  DEPTH       16   entries per channel (>=2)
//  NUM_CH      4    number of independent stacks (>=1)
//  CW = $clog2(NUM_CH) (min 1); PW = $clog2(DEPTH+1)  (derived, localparam)
// PORTS
//  clk        in   1              rising-edge clock
//  reset_n    in   1              async reset, active-low
//  push       in   1              push request
//  push_ch    in   CW             channel for push
//  push_data  in   DATA_WIDTH     value pushed
//  pop        in   1              pop request
//  pop_ch     in   CW             channel for pop and peek
//  clear      in   1              empty channel clear_ch this cycle
//  clear_ch   in   CW             channel to clear
//  pop_data   out  DATA_WIDTH     registered popped value
//  pop_valid  out  1              pop_data updated this cycle (1-cycle pulse)
//  peek_data  out  DATA_WIDTH     comb. top of pop_ch (undefined when empty)
//  count      out  PW             comb. occupancy of pop_ch
//  full       out  NUM_CH         per channel, count==DEPTH
//  empty      out  NUM_CH         per channel, count==0
//  overflow   out  NUM_CH         sticky: push dropped on full
//  underflow  out  NUM_CH         sticky: pop on empty
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
//    While reset_n=0: all counts=0, pop_valid=0, pop_data=0, overflow=0,
//    underflow=0. Memory is not reset.
//  - Pop latency: 1 cycle. Pop accepted at edge N -> pop_data/pop_valid valid after N.
//    pop_data holds its last value while pop_valid=0.
//  - Per channel c, at each edge, decisions use the pre-edge count.
//    Let P = push&&push_ch==c and Q = pop&&pop_ch==c. Priority:
//     1. clear&&clear_ch==c: count<=0, overflow[c]<=0, underflow[c]<=0.
//        Any P/Q on c is ignored (no pop_valid, no flags).
//     2. P&&Q, count>0 (replace-top): pop_data<=mem[count-1],
//        mem[count-1]<=push_data, pop_valid<=1, count unchanged.
//        Also applies when full; no overflow.
//     3. P&&Q, count==0: push accepted (count<=1). Pop rejected:
//        underflow[c]<=1, pop_valid<=0. No bypass of push_data.
//     4. P only: if count<DEPTH then mem[count]<=push_data, count+1;
//        else drop and overflow[c]<=1.
//     5. Q only: if count>0 then pop_data<=mem[count-1], count-1,
//        pop_valid<=1; else underflow[c]<=1.
//  - Push and pop on different channels proceed independently in the same cycle.
//  - Channel index >= NUM_CH: the request is ignored, no flag.
//  - count never wraps; bounded to 0..DEPTH.
//  - Reset asserted mid-operation: the in-flight pop is lost and
//    pop_valid=0 immediately.
//  - Simulation $display/$write tracing is not permitted in this block.
// STRUCTURE
//  - Package stack_pkg:
//    - function clog2_min1()
//    - typedef enum stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR}
//  - Sub-module stack_lane: a single channel's storage plus counter,
//    driven by a decoded stack_op_e. It outputs top, count, full, empty,
//    ovf and unf.
//  - multi_stack: generates NUM_CH lanes, decodes ops, muxes
//    pop_data/peek_data/count by pop_ch, and owns the pop_data/pop_valid registers.
// TESTING (DATA_WIDTH=8, DEPTH=4, NUM_CH=4)
//  1. Reset, then push 0x11,0x22,0x33 on ch1, then 3 pops on ch1 ->
//     pop_valid each following cycle with 0x33,0x22,0x11; then empty[1]=1.
//  2. Fill ch2 with 4 values -> full[2]=1. Push 0x99 -> dropped, overflow[2]=1,
//     count stays 4. Then push+pop ch2 with 0x55 -> pop_data=4th value,
//     peek_data=0x55, no new overflow.
//  3. Pop on empty ch0 -> pop_valid=0, underflow[0]=1.
//     Then same-cycle push 0x7 + pop on ch0 -> count=1, pop_valid=0.
//  4. Same cycle: push 0xA to ch3 while popping ch1 (holding 0x5) ->
//     pop_data=0x5, count(ch3)=1; channel states are independent.
//  5. clear ch2 while it is full with overflow set, plus push ch2 the same cycle ->
//     count(ch2)=0, overflow[2]=0, push ignored.
//  6. Assert reset_n=0 mid-burst between clock edges -> all outputs
//     zero/empty immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and helpers for the multi-channel LIFO stack.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_CLEAR
    } stack_op_e;

    // $clog2 that never returns 0, so single-entry selects still get a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stack_lane.sv
// One LIFO channel: storage, occupancy counter and sticky overflow/underflow flags.
module stack_lane
    import stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned PW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  stack_op_e             op_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic [DATA_WIDTH-1:0] top_o,
    output logic [PW-1:0]         count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  ovf_o,
    output logic                  unf_o
);

    localparam int unsigned AW = clog2_min1(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [AW-1:0]         top_idx;

    assign full_o  = (count_q == PW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign top_idx = AW'(count_q - PW'(1));
    assign top_o   = mem_q[top_idx];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = AW'(count_q);
        unique case (op_i)
            OP_CLEAR: begin
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            OP_PUSH: begin
                if (!full_o) begin
                    we      = 1'b1;
                    count_d = count_q + PW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty_o) count_d = count_q - PW'(1);
                else          unf_d   = 1'b1;
            end
            OP_REPLACE: begin
                we = 1'b1;
                if (!empty_o) begin
                    waddr = top_idx;
                end else begin
                    // Empty: the push still lands, only the pop half is rejected.
                    count_d = PW'(1);
                    unf_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem_q[waddr] <= push_data_i;
    end

endmodule

// File: rtl/multi_stack.sv
// NUM_CH independent LIFO stacks behind one push port and one pop/peek port.
module multi_stack
    import stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_CH     = 4,
    localparam int unsigned CW        = clog2_min1(NUM_CH),
    localparam int unsigned PW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [CW-1:0]         push_ch_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic [CW-1:0]         pop_ch_i,
    input  logic                  clear_i,
    input  logic [CW-1:0]         clear_ch_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] peek_data_o,
    output logic [PW-1:0]         count_o,
    output logic [NUM_CH-1:0]     full_o,
    output logic [NUM_CH-1:0]     empty_o,
    output logic [NUM_CH-1:0]     overflow_o,
    output logic [NUM_CH-1:0]     underflow_o
);

    logic [DATA_WIDTH-1:0] lane_top   [NUM_CH];
    logic [PW-1:0]         lane_count [NUM_CH];

    logic [DATA_WIDTH-1:0] sel_top;
    logic [PW-1:0]         sel_count;
    logic                  sel_empty;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  pop_valid_q, pop_valid_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic      p, q, clr;
        stack_op_e op;

        // Out-of-range channel selects match no lane and are silently dropped.
        assign p   = push_i  && (push_ch_i  == CW'(c));
        assign q   = pop_i   && (pop_ch_i   == CW'(c));
        assign clr = clear_i && (clear_ch_i == CW'(c));
        assign op  = clr      ? OP_CLEAR   :
                     (p && q) ? OP_REPLACE :
                     p        ? OP_PUSH    :
                     q        ? OP_POP     : OP_NONE;

        stack_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .op_i        (op),
            .push_data_i (push_data_i),
            .top_o       (lane_top[c]),
            .count_o     (lane_count[c]),
            .full_o      (full_o[c]),
            .empty_o     (empty_o[c]),
            .ovf_o       (overflow_o[c]),
            .unf_o       (underflow_o[c])
        );
    end

    always_comb begin
        sel_top   = '0;
        sel_count = '0;
        sel_empty = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_ch_i == CW'(c)) begin
                sel_top   = lane_top[c];
                sel_count = lane_count[c];
                sel_empty = empty_o[c];
            end
        end
    end

    assign peek_data_o = sel_top;
    assign count_o     = sel_count;

    // A clear on the popped channel wins over the pop.
    assign pop_ok      = pop_i && !sel_empty && !(clear_i && (clear_ch_i == pop_ch_i));
    assign pop_valid_d = pop_ok;
    assign pop_data_d  = pop_ok ? sel_top : pop_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
        end
    end

    assign pop_valid_o = pop_valid_q;
    assign pop_data_o  = pop_data_q;

endmodule
